// File: rtl/lsu_seq_if.sv
// Execute-side request/response and memory-side bus of the sequential load/store unit.
interface lsu_seq_if;
  // Request from execute
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  op;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic [11:0] offset;
  logic [4:0]  rd;
  // Memory transaction bus
  logic        mem_req;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic        mem_ack;
  logic [31:0] drdata;
  // Response to writeback
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [1:0]  resp_cause;

  // Environment side: execute stage plus memory
  modport master (
    output req_valid, op, rv1, rv2, offset, rd, mem_ack, drdata,
    input  req_ready, mem_req, daddr, dwdata, dwe,
           resp_valid, resp_data, resp_rd, resp_fault, resp_cause
  );

  // Load/store unit side
  modport slave (
    input  req_valid, op, rv1, rv2, offset, rd, mem_ack, drdata,
    output req_ready, mem_req, daddr, dwdata, dwe,
           resp_valid, resp_data, resp_rd, resp_fault, resp_cause
  );
endinterface

// File: rtl/lsu_seq.sv
// Sequential handshaked RV32 load/store unit: one or two word transactions per
// request, optional misaligned splitting, per-transaction timeout, fault reporting.
module lsu_seq #(
  parameter bit          MISALIGN_SPLIT = 1'b1,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic     clk,
  input  logic     reset,
  lsu_seq_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // Store data placed on byte lanes across the two words touched
  function automatic logic [63:0] lane_data(input logic [31:0] d, input logic [1:0] off);
    return {32'h0, d} << {off, 3'b000};
  endfunction

  // Byte enables across the two words touched
  function automatic logic [7:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  // Access spills into the next word
  function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off == 2'd3;
      default: return off != 2'd0;
    endcase
  endfunction

  // Align, truncate and extend load data
  function automatic logic [31:0] load_ext(input logic [63:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = 32'(w >> {off, 3'b000});
    case (sz)
      SZ_B:    return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      SZ_H:    return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        sz_q, sz_d;
  logic              store_q, store_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic              cross_q, cross_d;
  logic [29:0]       ea_hi_q, ea_hi_d;
  logic [31:0]       rv2_q, rv2_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       daddr_q, daddr_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [3:0]        dwe_q, dwe_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic              resp_fault_q, resp_fault_d;
  logic [1:0]        resp_cause_q, resp_cause_d;

  logic              dec_legal, dec_store, dec_uns;
  logic [1:0]        dec_sz;
  logic [31:0]       in_ea;
  logic              in_cross;
  logic [63:0]       in_d64, q_d64;
  logic [7:0]        in_be8, q_be8;
  logic [63:0]       ld_word;
  logic              tmo_hit;

  // Opcode decode of the incoming request
  always_comb begin
    dec_legal = 1'b1;
    dec_store = 1'b0;
    dec_uns   = 1'b0;
    dec_sz    = SZ_W;
    case (bus.op)
      6'h10:   dec_sz = SZ_B;
      6'h11:   dec_sz = SZ_H;
      6'h12:   dec_sz = SZ_W;
      6'h14:   begin dec_sz = SZ_B; dec_uns = 1'b1; end
      6'h15:   begin dec_sz = SZ_H; dec_uns = 1'b1; end
      6'h18:   begin dec_sz = SZ_B; dec_store = 1'b1; end
      6'h19:   begin dec_sz = SZ_H; dec_store = 1'b1; end
      6'h1A:   begin dec_sz = SZ_W; dec_store = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign in_ea    = bus.rv1 + {{20{bus.offset[11]}}, bus.offset};
  assign in_cross = crosses(dec_sz, in_ea[1:0]);
  assign in_d64   = lane_data(bus.rv2, in_ea[1:0]);
  assign in_be8   = lane_be(dec_sz, in_ea[1:0]);
  assign q_d64    = lane_data(rv2_q, off_q);
  assign q_be8    = lane_be(sz_q, off_q);
  assign ld_word  = (state_q == ACC1) ? {bus.drdata, lo_q} : {32'h0, bus.drdata};
  assign tmo_hit  = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    sz_d         = sz_q;
    store_d      = store_q;
    uns_d        = uns_q;
    off_d        = off_q;
    cross_d      = cross_q;
    ea_hi_d      = ea_hi_q;
    rv2_d        = rv2_q;
    rd_d         = rd_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    mem_req_d    = 1'b0;
    daddr_d      = daddr_q;
    dwdata_d     = 32'h0;
    dwe_d        = 4'h0;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_fault_d = resp_fault_q;
    resp_cause_d = resp_cause_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          sz_d    = dec_sz;
          store_d = dec_store;
          uns_d   = dec_uns;
          off_d   = in_ea[1:0];
          cross_d = in_cross;
          ea_hi_d = in_ea[31:2];
          rv2_d   = bus.rv2;
          rd_d    = bus.rd;
          if (!dec_legal || (in_cross && !MISALIGN_SPLIT)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = 32'h0;
            resp_rd_d    = bus.rd;
            resp_fault_d = 1'b1;
            resp_cause_d = dec_legal ? CAUSE_MISALIGN : CAUSE_ILLEGAL;
          end else begin
            state_d   = ACC0;
            cnt_d     = '0;
            mem_req_d = 1'b1;
            daddr_d   = {in_ea[31:2], 2'b00};
            dwdata_d  = in_d64[31:0];
            dwe_d     = dec_store ? in_be8[3:0] : 4'h0;
          end
        end
      end

      ACC0, ACC1: begin
        if (bus.mem_ack) begin
          if (state_q == ACC0 && cross_q) begin
            lo_d      = bus.drdata;
            state_d   = ACC1;
            cnt_d     = '0;
            mem_req_d = 1'b1;
            daddr_d   = {ea_hi_q + 30'd1, 2'b00};
            dwdata_d  = q_d64[63:32];
            dwe_d     = store_q ? q_be8[7:4] : 4'h0;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = store_q ? 32'h0 : load_ext(ld_word, off_q, sz_q, uns_q);
            resp_rd_d    = rd_q;
            resp_fault_d = 1'b0;
            resp_cause_d = 2'b00;
          end
        end else if (tmo_hit) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = 32'h0;
          resp_rd_d    = rd_q;
          resp_fault_d = 1'b1;
          resp_cause_d = CAUSE_TIMEOUT;
        end else begin
          // Hold the transaction stable while waiting for the ack
          if (TIMEOUT != 0) cnt_d = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
          dwdata_d  = dwdata_q;
          dwe_d     = dwe_q;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sz_q         <= SZ_B;
      store_q      <= 1'b0;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
      cross_q      <= 1'b0;
      ea_hi_q      <= 30'h0;
      rv2_q        <= 32'h0;
      rd_q         <= 5'h0;
      lo_q         <= 32'h0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      daddr_q      <= 32'h0;
      dwdata_q     <= 32'h0;
      dwe_q        <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_rd_q    <= 5'h0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      sz_q         <= sz_d;
      store_q      <= store_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      cross_q      <= cross_d;
      ea_hi_q      <= ea_hi_d;
      rv2_q        <= rv2_d;
      rd_q         <= rd_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      daddr_q      <= daddr_d;
      dwdata_q     <= dwdata_d;
      dwe_q        <= dwe_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_fault_q <= resp_fault_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.daddr      = daddr_q;
  assign bus.dwdata     = dwdata_q;
  assign bus.dwe        = dwe_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_cause = resp_cause_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: split-enabled unit (TIMEOUT=4) plus a split-disabled unit.
module tb_lsu_seq;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  lsu_seq_if ifa ();
  lsu_seq_if ifb ();

  lsu_seq #(.MISALIGN_SPLIT(1'b1), .TIMEOUT(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  lsu_seq #(.MISALIGN_SPLIT(1'b0), .TIMEOUT(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; returns in cycle T+1 after the accept edge
  task automatic issue(input bit sel_b, input logic [5:0] op, input logic [31:0] rv1,
                       input logic [31:0] rv2, input logic [11:0] off, input logic [4:0] rd);
    if (sel_b) begin
      ifb.req_valid = 1'b1; ifb.op = op; ifb.rv1 = rv1; ifb.rv2 = rv2; ifb.offset = off; ifb.rd = rd;
    end else begin
      ifa.req_valid = 1'b1; ifa.op = op; ifa.rv1 = rv1; ifa.rv2 = rv2; ifa.offset = off; ifa.rd = rd;
    end
    tick();
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
  endtask

  // Acknowledge the current transaction of unit A for one cycle
  task automatic ack_a(input logic [31:0] d);
    ifa.mem_ack = 1'b1;
    ifa.drdata  = d;
    tick();
    ifa.mem_ack = 1'b0;
    ifa.drdata  = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifa.req_valid = 1'b0; ifa.op = 6'h0; ifa.rv1 = 32'h0; ifa.rv2 = 32'h0;
    ifa.offset = 12'h0; ifa.rd = 5'h0; ifa.mem_ack = 1'b0; ifa.drdata = 32'h0;
    ifb.req_valid = 1'b0; ifb.op = 6'h0; ifb.rv1 = 32'h0; ifb.rv2 = 32'h0;
    ifb.offset = 12'h0; ifb.rd = 5'h0; ifb.mem_ack = 1'b0; ifb.drdata = 32'h0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst.req_ready",  ifa.req_ready,  1);
    check("rst.mem_req",    ifa.mem_req,    0);
    check("rst.daddr",      ifa.daddr,      0);
    check("rst.dwdata",     ifa.dwdata,     0);
    check("rst.dwe",        ifa.dwe,        0);
    check("rst.resp_valid", ifa.resp_valid, 0);
    check("rst.resp_data",  ifa.resp_data,  0);
    check("rst.resp_rd",    ifa.resp_rd,    0);
    check("rst.resp_fault", ifa.resp_fault, 0);
    check("rst.resp_cause", ifa.resp_cause, 0);
    reset = 1'b1;
    tick();
    check("idle.req_ready", ifa.req_ready, 1);

    // Aligned LW, zero-wait ack
    issue(0, 6'h12, 32'h100, 32'h0, 12'h004, 5'd5);
    check("lw.mem_req",   ifa.mem_req,   1);
    check("lw.daddr",     ifa.daddr,     32'h104);
    check("lw.dwe",       ifa.dwe,       0);
    check("lw.req_ready", ifa.req_ready, 0);
    ack_a(32'h8765_4321);
    check("lw.resp_valid", ifa.resp_valid, 1);
    check("lw.resp_data",  ifa.resp_data,  32'h8765_4321);
    check("lw.resp_rd",    ifa.resp_rd,    5);
    check("lw.resp_fault", ifa.resp_fault, 0);
    check("lw.mem_req_off", ifa.mem_req,   0);
    tick();
    check("lw.valid_drop", ifa.resp_valid, 0);
    check("lw.ready_back", ifa.req_ready,  1);
    check("lw.data_hold",  ifa.resp_data,  32'h8765_4321);

    // LB at offset 3, sign-extended
    issue(0, 6'h10, 32'h300, 32'h0, 12'h003, 5'd1);
    check("lb.daddr", ifa.daddr, 32'h300);
    ack_a(32'h8012_3456);
    check("lb.resp_valid", ifa.resp_valid, 1);
    check("lb.resp_data",  ifa.resp_data,  32'hFFFF_FF80);
    tick();

    // LBU at offset 3 with one wait cycle
    issue(0, 6'h14, 32'h300, 32'h0, 12'h003, 5'd2);
    check("lbu.mem_req", ifa.mem_req, 1);
    tick();
    check("lbu.wait_mem_req", ifa.mem_req,    1);
    check("lbu.wait_daddr",   ifa.daddr,      32'h300);
    check("lbu.wait_valid",   ifa.resp_valid, 0);
    ack_a(32'h80AA_BBCC);
    check("lbu.resp_valid", ifa.resp_valid, 1);
    check("lbu.resp_data",  ifa.resp_data,  32'h0000_0080);
    check("lbu.resp_rd",    ifa.resp_rd,    2);
    tick();

    // LH at offset 2, sign-extended
    issue(0, 6'h11, 32'h600, 32'h0, 12'h002, 5'd3);
    check("lh.daddr", ifa.daddr, 32'h600);
    ack_a(32'h9ABC_0000);
    check("lh.resp_data", ifa.resp_data, 32'hFFFF_9ABC);
    tick();

    // SB at offset 1
    issue(0, 6'h18, 32'h1000, 32'h0000_00AB, 12'h001, 5'd4);
    check("sb.daddr",  ifa.daddr,  32'h1000);
    check("sb.dwe",    ifa.dwe,    4'b0010);
    check("sb.dwdata", ifa.dwdata, 32'h0000_AB00);
    ack_a(32'hDEAD_BEEF);
    check("sb.resp_valid", ifa.resp_valid, 1);
    check("sb.resp_data",  ifa.resp_data,  0);
    check("sb.resp_fault", ifa.resp_fault, 0);
    check("sb.dwe_off",    ifa.dwe,        0);
    tick();

    // Split LW at ea 0x203
    issue(0, 6'h12, 32'h200, 32'h0, 12'h003, 5'd7);
    check("slw.daddr0", ifa.daddr, 32'h200);
    ack_a(32'h1122_3344);
    check("slw.mem_req1", ifa.mem_req,    1);
    check("slw.daddr1",   ifa.daddr,      32'h204);
    check("slw.valid1",   ifa.resp_valid, 0);
    ack_a(32'h5566_7788);
    check("slw.resp_valid", ifa.resp_valid, 1);
    check("slw.resp_data",  ifa.resp_data,  32'h6677_8811);
    check("slw.resp_rd",    ifa.resp_rd,    7);
    tick();

    // Split SH at ea 0x3FF (negative offset)
    issue(0, 6'h19, 32'h400, 32'h0000_BEEF, 12'hFFF, 5'd8);
    check("ssh.daddr0",  ifa.daddr,  32'h3FC);
    check("ssh.dwe0",    ifa.dwe,    4'b1000);
    check("ssh.dwdata0", ifa.dwdata, 32'hEF00_0000);
    ack_a(32'h0);
    check("ssh.daddr1",  ifa.daddr,  32'h400);
    check("ssh.dwe1",    ifa.dwe,    4'b0001);
    check("ssh.dwdata1", ifa.dwdata, 32'h0000_00BE);
    ack_a(32'h0);
    check("ssh.resp_valid", ifa.resp_valid, 1);
    check("ssh.resp_fault", ifa.resp_fault, 0);
    tick();

    // Same split SH on the split-disabled unit faults immediately
    issue(1, 6'h19, 32'h400, 32'h0000_BEEF, 12'hFFF, 5'd8);
    check("nsplit.resp_valid", ifb.resp_valid, 1);
    check("nsplit.resp_fault", ifb.resp_fault, 1);
    check("nsplit.resp_cause", ifb.resp_cause, 2'b01);
    check("nsplit.mem_req",    ifb.mem_req,    0);
    check("nsplit.resp_rd",    ifb.resp_rd,    8);
    tick();
    check("nsplit.valid_drop", ifb.resp_valid, 0);
    check("nsplit.mem_req2",   ifb.mem_req,    0);

    // Illegal opcode 0x13
    issue(0, 6'h13, 32'h100, 32'h0, 12'h000, 5'd9);
    check("ill.resp_valid", ifa.resp_valid, 1);
    check("ill.resp_fault", ifa.resp_fault, 1);
    check("ill.resp_cause", ifa.resp_cause, 2'b11);
    check("ill.resp_data",  ifa.resp_data,  0);
    check("ill.resp_rd",    ifa.resp_rd,    9);
    check("ill.mem_req",    ifa.mem_req,    0);
    tick();

    // Timeout: no ack for four cycles
    issue(0, 6'h12, 32'h500, 32'h0, 12'h000, 5'd10);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tmo.mem_req%0d", i), ifa.mem_req,    1);
      check($sformatf("tmo.valid%0d", i),   ifa.resp_valid, 0);
      tick();
    end
    check("tmo.mem_req_drop", ifa.mem_req,    0);
    check("tmo.resp_valid",   ifa.resp_valid, 1);
    check("tmo.resp_fault",   ifa.resp_fault, 1);
    check("tmo.resp_cause",   ifa.resp_cause, 2'b10);
    check("tmo.resp_data",    ifa.resp_data,  0);
    check("tmo.resp_rd",      ifa.resp_rd,    10);
    tick();

    // Reset asserted while in ACC1
    issue(0, 6'h12, 32'h200, 32'h0, 12'h003, 5'd11);
    ack_a(32'h1122_3344);
    check("rstacc.mem_req_pre", ifa.mem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstacc.mem_req",    ifa.mem_req,    0);
    check("rstacc.resp_valid", ifa.resp_valid, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("rstacc.no_resp",   ifa.resp_valid, 0);
    check("rstacc.req_ready", ifa.req_ready,  1);
    check("rstacc.mem_req2",  ifa.mem_req,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Sequential, handshaked load/store unit for the RV32 core; the multi-cycle successor to the single-cycle combinational load/store path. Accepts one load/store per request from execute, issues one or two word-aligned memory transactions with a request/acknowledge handshake, and returns the sign/zero-extended load result or a fault to writeback. Adds configurable misaligned-access splitting, a memory timeout, and fault reporting.

## Interface
- MISALIGN_SPLIT, 1, 1: misaligned accesses crossing a word boundary are split into two transactions; 0: they fault.
- TIMEOUT, 16, cycles to wait for `mem_ack` per transaction before faulting; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- op  in  6  opcode: 10 LB, 11 LH, 12 LW, 14 LBU, 15 LHU, 18 SB, 19 SH, 1A SW (hex); all others illegal.
- rv1  in  32  base register.
- rv2  in  32  store data.
- offset  in  12  signed immediate.
- rd  in  5  destination register tag.
- mem_req  out  1  transaction valid.
- daddr  out  32  word-aligned address (`ea & ~3`, or `+4` for second half).
- dwdata  out  32  lane-aligned store data.
- dwe  out  4  byte write enables; 0 means read.
- mem_ack  in  1  transaction complete; `drdata` valid in the same cycle.
- drdata  in  32  read data.
- resp_valid  out  1  one-cycle result strobe.
- resp_data  out  32  extended load data; 0 for stores and faults.
- resp_rd  out  5  captured `rd`.
- resp_fault  out  1  request faulted.
- resp_cause  out  2  01 misaligned, 10 timeout, 11 illegal op, 00 none.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: `req_ready`=1. When `req_valid` is high, capture op, rv2, rd and `ea = rv1 + sext(offset)` (mod 2^32). Compute `off = ea[1:0]`, size (1/2/4), and `cross = off + size > 4`.
  - Illegal op: go to RESP, cause 11.
  - `cross` with MISALIGN_SPLIT=0: go to RESP, cause 01.
  - Otherwise go to ACC0.
- Store lanes: `data64 = {32'b0, rv2} << 8*off`, `be8 = mask(size) << off`.
  - ACC0 drives `data64[31:0]` / `be8[3:0]`.
  - ACC1 drives `data64[63:32]` / `be8[7:4]`.
- ACC0: `mem_req`=1, `daddr = ea & ~3`. On `mem_ack`, loads latch `drdata` into `lo`. Then go to ACC1 if `cross`, else RESP.
- ACC1: `mem_req`=1, `daddr = (ea & ~3) + 4` (wraps mod 2^32). On `mem_ack`, latch `hi`, then go to RESP.
- Load result: `({hi, lo} >> 8*off)`, truncated to size, then sign-extended (LB, LH) or zero-extended (LBU, LHU). `hi` is don't-care when not crossing.
- Timeout: the counter clears on entry to ACC0/ACC1 and increments each cycle without `mem_ack`. When it reaches TIMEOUT, drop `mem_req` and go to RESP with cause 10. A partially committed split store (ACC0 written) is not rolled back.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. The consumer cannot stall it.
- Outside ACC0/ACC1: `mem_req`=0, `dwe`=0, `dwdata`=0.

## Timing
- Reset (async assert, sync-safe deassert) gives: state IDLE, `req_ready`=1, `mem_req`=0, `daddr`=0, `dwdata`=0, `dwe`=0, `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `resp_fault`=0, `resp_cause`=0.
- Reset asserted mid-transaction drops `mem_req` immediately, and no response is issued.
- Accept at edge T:
  - `mem_req` is high from T+1.
  - With zero-wait ack, `resp_valid` is high in cycle T+2 for an unsplit access and T+3 for a split access.
  - Each ack wait cycle adds 1.
- Fault detected at accept: `resp_valid` in T+1, and no memory transaction is issued.
- `mem_req`, `daddr`, `dwdata`, `dwe` are stable from assertion until the `mem_ack` cycle.
- `req_ready` is low from the cycle after accept until the cycle after RESP.
- `resp_*` are registered and hold their value until the next RESP.

## Test plan
- LW aligned: rv1=0x100, off=4, drdata=0x8765_4321, ack at zero wait:
  - `daddr`=0x104, `dwe`=0.
  - `resp_data`=0x8765_4321, `resp_valid` at T+2.
- LB/LBU at off 3, drdata=0x80xx_xxxx: LB gives 0xFFFF_FF80, LBU gives 0x0000_0080. SB rv2=0xAB at off 1 gives `dwe`=0010, `dwdata`=0x0000_AB00.
- Split LW, ea=0x203, MISALIGN_SPLIT=1:
  - First transaction `daddr`=0x200, returns 0x1122_3344.
  - Second transaction `daddr`=0x204, returns 0x5566_7788.
  - `resp_data`=0x6677_8811.
- Split SH, ea=0x3FF, rv2=0xBEEF:
  - First transaction `daddr`=0x3FC, `dwe`=1000, `dwdata`=0xEF00_0000.
  - Second transaction `daddr`=0x400, `dwe`=0001, `dwdata`=0x0000_00BE.
  - With MISALIGN_SPLIT=0: fault, cause 01, no `mem_req`.
- Illegal op 0x13 gives cause 11 at T+1. No `mem_ack` for TIMEOUT=4 cycles gives `mem_req` low and cause 10.
- Reset asserted while in ACC1 gives `mem_req`=0 in the same cycle, no `resp_valid`, and `req_ready`=1 after release.
